// File: rtl/cache_types.sv
// Shared cache-subsystem types: arbiter FSM states and line geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_types;

    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        arb_idle  = 2'd0,
        arb_busy0 = 2'd1,
        arb_busy1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: favours the port that was not granted last on a tie.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
//
// Ports:
//   req[1:0]  - request vector, bit k = port k requesting
//   last      - index of the most recently granted port
//   gnt_valid - at least one request present
//   gnt_idx   - chosen port (meaningful only with gnt_valid)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;   // tie goes to whoever waited
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_dfp_arbiter.sv
// Shares one line-burst memory port between two cache downstream ports, round-robin, non-preemptive.
// Latency: grant drives mem_* one cycle after request seen in IDLE; mem_resp forwarded same cycle.
// Backpressure: requests are level-held until resp; the loser simply stays pending, nothing is dropped.
//
// Ports:
//   clk, rst             - clock, synchronous active-low reset
//   up0_* / up1_*        - requester ports (addr, read, write, wdata in; rdata, resp out)
//   mem_*                - shared memory port (addr, read, write, wdata out; rdata, resp in)
module cache_dfp_arbiter
    import cache_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = cache_types::LINE_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] up0_addr,
    input  logic              up0_read,
    input  logic              up0_write,
    input  logic [LINE_W-1:0] up0_wdata,
    output logic [LINE_W-1:0] up0_rdata,
    output logic              up0_resp,

    input  logic [ADDR_W-1:0] up1_addr,
    input  logic              up1_read,
    input  logic              up1_write,
    input  logic [LINE_W-1:0] up1_wdata,
    output logic [LINE_W-1:0] up1_rdata,
    output logic              up1_resp,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t r_state;
    logic       r_last;

    logic [1:0] w_req;
    logic       w_gnt_vld;
    logic       w_gnt_idx;

    assign w_req = {up1_read | up1_write, up0_read | up0_write};

    rr_pick2 u_pick (
        .req       (w_req),
        .last      (r_last),
        .gnt_valid (w_gnt_vld),
        .gnt_idx   (w_gnt_idx)
    );

    // Reset leaves last = 1 so port 0 wins the first tie.
    // A granted transaction is in flight at the memory, so BUSYk only
    // ends on mem_resp even if the requester drops its strobe early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= arb_idle;
            r_last  <= 1'b1;
        end else begin
            unique case (r_state)
                arb_idle: begin
                    if (w_gnt_vld) begin
                        r_state <= w_gnt_idx ? arb_busy1 : arb_busy0;
                        r_last  <= w_gnt_idx;
                    end
                end
                arb_busy0, arb_busy1: begin
                    if (mem_resp) r_state <= arb_idle;
                end
                default: r_state <= arb_idle;
            endcase
        end
    end

    // Read data is broadcast; only resp qualifies it.
    assign up0_rdata = mem_rdata;
    assign up1_rdata = mem_rdata;

    // IDLE drives zeros, which also swallows a stray mem_resp.
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        up0_resp  = 1'b0;
        up1_resp  = 1'b0;
        unique case (r_state)
            arb_busy0: begin
                mem_addr  = up0_addr;
                mem_read  = up0_read;
                mem_write = up0_write;
                mem_wdata = up0_wdata;
                up0_resp  = mem_resp;
            end
            arb_busy1: begin
                mem_addr  = up1_addr;
                mem_read  = up1_read;
                mem_write = up1_write;
                mem_wdata = up1_wdata;
                up1_resp  = mem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
module tb_cache_dfp_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  up0_addr, up1_addr, mem_addr;
    logic         up0_read, up0_write, up1_read, up1_write;
    logic [255:0] up0_wdata, up1_wdata, up0_rdata, up1_rdata;
    logic         up0_resp, up1_resp;
    logic         mem_read, mem_write, mem_resp;
    logic [255:0] mem_wdata, mem_rdata;

    cache_dfp_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .up0_addr  (up0_addr),
        .up0_read  (up0_read),
        .up0_write (up0_write),
        .up0_wdata (up0_wdata),
        .up0_rdata (up0_rdata),
        .up0_resp  (up0_resp),
        .up1_addr  (up1_addr),
        .up1_read  (up1_read),
        .up1_write (up1_write),
        .up1_wdata (up1_wdata),
        .up1_rdata (up1_rdata),
        .up1_resp  (up1_resp),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           port;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_resp_cyc = 0;

    logic [255:0] R0    = {8{32'h0BAD_F00D}};
    logic [255:0] DEAD  = {8{32'hDEAD_BEEF}};
    logic [255:0] A5    = {32{8'hA5}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request on port k and record what the memory side must see.
    task automatic present(input bit k, input bit wr, input logic [31:0] a, input logic [255:0] wd);
        txn_t t;
        t.port = k; t.wr = wr; t.addr = a; t.wdata = wd;
        if (k == 1'b0) begin
            up0_read = !wr; up0_write = wr; up0_addr = a; up0_wdata = wd;
        end else begin
            up1_read = !wr; up1_write = wr; up1_addr = a; up1_wdata = wd;
        end
        exp_q.push_back(t);
    endtask

    // Memory model for one transaction: waits for the strobe, checks it against
    // the scoreboard head, returns resp after lat cycles, then checks the dead cycle.
    task automatic serve(input int lat, input logic [255:0] rd, input int exp_start);
        txn_t e;
        int   waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!(mem_read || mem_write) && waited < 20);
        chk("start_seen", 256'(mem_read | mem_write), 256'(1));
        chk("start_cycle", 256'(cyc), 256'(exp_start));
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: empty at cycle %0d", cyc);
            $fatal(1, "scoreboard empty");
        end
        e = exp_q.pop_front();
        chk("mem_addr", 256'(mem_addr), 256'(e.addr));
        chk("mem_read", 256'(mem_read), 256'(!e.wr));
        chk("mem_write", 256'(mem_write), 256'(e.wr));
        chk("mem_wdata", mem_wdata, e.wdata);
        for (int i = 1; i < lat; i++) begin
            chk("busy_resp", 256'({up1_resp, up0_resp}), 256'(0));
            chk("rw_excl", 256'(mem_read & mem_write), 256'(0));
            @(negedge clk);
            if (i == lat - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = rd;
            end
            #1;
            chk("hold", 256'(mem_read | mem_write), 256'(1));
        end
        chk("resp0", 256'(up0_resp), 256'(!e.port));
        chk("resp1", 256'(up1_resp), 256'(e.port));
        chk("rdata", e.port ? up1_rdata : up0_rdata, rd);
        last_resp_cyc = cyc;
        @(negedge clk);
        mem_resp = 1'b0;
        if (e.port == 1'b0) begin up0_read = 1'b0; up0_write = 1'b0; end
        else                begin up1_read = 1'b0; up1_write = 1'b0; end
        #1;
        chk("dead_cycle", 256'({mem_read, mem_write}), 256'(0));
        chk("dead_resp", 256'({up1_resp, up0_resp}), 256'(0));
    endtask

    initial begin
        rst = 1'b0;
        up0_addr = '0; up0_read = 1'b0; up0_write = 1'b0; up0_wdata = '0;
        up1_addr = '0; up1_read = 1'b0; up1_write = 1'b0; up1_wdata = '0;
        mem_resp = 1'b0; mem_rdata = R0;

        // Reset: outputs idle, rdata broadcast.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobes", 256'({mem_read, mem_write}), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_resp", 256'({up1_resp, up0_resp}), 256'(0));
        chk("rst_rdata0", up0_rdata, R0);
        chk("rst_rdata1", up1_rdata, R0);

        // Simultaneous first requests after reset: port 0 first.
        @(negedge clk);
        rst = 1'b1;
        present(1'b0, 1'b0, 32'h100, '0);
        present(1'b1, 1'b1, 32'h200, DEAD);
        #1;
        chk("post_rst_strobes", 256'({mem_read, mem_write}), 256'(0));
        chk("post_rst_addr", 256'(mem_addr), 256'(0));
        serve(3, {8{32'h1111_0100}}, cyc + 1);
        serve(2, {8{32'h2222_0200}}, last_resp_cyc + 2);

        // Single read, 5-cycle memory.
        present(1'b0, 1'b0, 32'h0000_1040, {8{32'h5555_AAAA}});
        serve(5, A5, cyc + 1);

        // Writeback then allocate on port 1.
        present(1'b1, 1'b1, 32'h3E0, {8{32'hC0FF_EE00}});
        serve(2, {8{32'h3333_03E0}}, cyc + 1);
        present(1'b1, 1'b0, 32'h7E0, '0);
        serve(3, {8{32'h7777_07E0}}, last_resp_cyc + 2);

        // Saturation: last = 1 here, so grants run 0,1,0,1,0,1.
        present(1'b0, 1'b0, 32'h1000, '0);
        present(1'b1, 1'b1, 32'h2000, {8{32'h1000_0001}});
        for (int i = 0; i < 6; i++) begin
            bit p;
            p = i[0];
            serve(2 + (i % 3), {8{32'hF000_0000 | 32'(i)}}, (i == 0) ? cyc + 1 : last_resp_cyc + 2);
            if (i < 4)
                present(p, p, 32'h1000 * (32'(p) + 1) + 32'h20 * 32'(i + 1), {8{32'h2000_0000 | 32'(i)}});
        end

        // Stray mem_resp in IDLE.
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        chk("stray_resp", 256'({up1_resp, up0_resp}), 256'(0));
        chk("stray_strobes", 256'({mem_read, mem_write}), 256'(0));
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("stray_idle", 256'({mem_read, mem_write}), 256'(0));

        // Reset during BUSY0 abandons the transaction.
        up0_read = 1'b1; up0_addr = 32'h500;
        @(negedge clk); #1;
        chk("busy0_read", 256'(mem_read), 256'(1));
        chk("busy0_addr", 256'(mem_addr), 256'(32'h500));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abandon_strobes", 256'({mem_read, mem_write}), 256'(0));
        chk("abandon_addr", 256'(mem_addr), 256'(0));
        chk("abandon_resp", 256'({up1_resp, up0_resp}), 256'(0));

        // Tie after reset goes to port 0 even though port 0 was granted last.
        @(negedge clk);
        rst = 1'b1;
        present(1'b0, 1'b0, 32'h600, '0);
        present(1'b1, 1'b0, 32'h700, '0);
        serve(2, {8{32'h6666_0600}}, cyc + 1);
        serve(2, {8{32'h7777_0700}}, last_resp_cyc + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
